// File: rtl/dti_pack.sv
// Shared DTI PR NIU definitions: flit layout and transmit-stage state encoding.
package dti_pack;

  localparam int DTI_FLIT_WIDTH = 104;

  localparam int FLIT_LAST_BIT  = 0;
  localparam int FLIT_QOS_BIT   = 1;
  localparam int FLIT_TGTID_LSB = 2;
  localparam int FLIT_SRCID_LSB = 8;
  localparam int FLIT_PLD_LSB   = 14;

  typedef enum logic [1:0] {
    TX_RUN,
    TX_DRAIN,
    TX_QUIET
  } dti_tx_state_e;

endpackage

// File: rtl/dti_skid_buf2.sv
// Two-entry valid/ready FIFO buffer; in_rdy depends only on occupancy, so it
// never combinationally follows out_rdy.
module dti_skid_buf2 #(
  parameter int PLD_WIDTH = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [PLD_WIDTH-1:0] in_pld,
  output logic                 in_rdy,
  output logic                 out_vld,
  output logic [PLD_WIDTH-1:0] out_pld,
  input  logic                 out_rdy
);

  logic [PLD_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt;
  logic                 push;
  logic                 pop;

  assign in_rdy  = (cnt != 2'd2);
  assign out_vld = (cnt != 2'd0);
  assign out_pld = mem[rd_ptr];
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_pld;
  end

endmodule

// File: rtl/dti_pr_iniu_noc_tx.sv
// NoC-side transmit stage of the DTI PR initiator NIU: credit-gated flit
// injection with packet-atomic quiesce on partial_reset.
module dti_pr_iniu_noc_tx
  import dti_pack::*;
#(
  parameter int PLD_WIDTH    = DTI_FLIT_WIDTH,
  parameter int CREDIT_NUM   = 4,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 partial_reset,
  output logic                 idle,
  input  logic                 s_vld,
  input  logic [PLD_WIDTH-1:0] s_pld,
  output logic                 s_rdy,
  output logic                 link_vld,
  output logic [PLD_WIDTH-1:0] link_flit,
  input  logic                 link_crd_rtn,
  output logic                 crd_err
);

  localparam logic [CREDIT_WIDTH-1:0] CRD_MAX = CREDIT_WIDTH'(CREDIT_NUM);

  dti_tx_state_e          state, state_nxt;
  logic [CREDIT_WIDTH-1:0] credit, credit_nxt;
  logic                   crd_full;
  logic                   crd_ovf;
  logic                   pkt_open;
  logic                   accept_ok;
  logic                   accept;
  logic                   buf_in_rdy;
  logic                   buf_vld;
  logic [PLD_WIDTH-1:0]   buf_pld;
  logic                   send;

  assign crd_full  = (credit == CRD_MAX);
  assign accept_ok = (state == TX_RUN) | ((state == TX_DRAIN) & pkt_open);
  assign s_rdy     = buf_in_rdy & accept_ok;
  assign accept    = s_vld & s_rdy;
  assign send      = buf_vld & (credit != '0);
  assign idle      = ~buf_vld & ~pkt_open & crd_full & ~link_vld;

  dti_skid_buf2 #(
    .PLD_WIDTH (PLD_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (s_vld & accept_ok),
    .in_pld  (s_pld),
    .in_rdy  (buf_in_rdy),
    .out_vld (buf_vld),
    .out_pld (buf_pld),
    .out_rdy (send)
  );

  // A return with no send at full credit is a router protocol error; saturate.
  always_comb begin
    credit_nxt = credit;
    crd_ovf    = 1'b0;
    case ({send, link_crd_rtn})
      2'b10: credit_nxt = credit - 1'b1;
      2'b01: begin
        if (crd_full) crd_ovf    = 1'b1;
        else          credit_nxt = credit + 1'b1;
      end
      default: credit_nxt = credit;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_RUN:   if (partial_reset) state_nxt = TX_DRAIN;
      TX_DRAIN: begin
        if (!partial_reset)                       state_nxt = TX_RUN;
        else if (!pkt_open && !buf_vld && crd_full) state_nxt = TX_QUIET;
      end
      TX_QUIET: if (!partial_reset) state_nxt = TX_RUN;
      default:  state_nxt = TX_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TX_RUN;
      credit    <= CRD_MAX;
      crd_err   <= 1'b0;
      pkt_open  <= 1'b0;
      link_vld  <= 1'b0;
      link_flit <= '0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      link_vld <= send;
      if (crd_ovf) crd_err  <= 1'b1;
      if (accept)  pkt_open <= ~s_pld[FLIT_LAST_BIT];
      if (send)    link_flit <= buf_pld;
    end
  end

endmodule

// File: tb/tb_dti_pr_iniu_noc_tx.sv
// Randomized and scenario-driven bench for dti_pr_iniu_noc_tx against a
// queue-based cycle model of the transmit stage.
module tb_dti_pr_iniu_noc_tx;

  localparam int W = 104;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         partial_reset;
  logic         idle;
  logic         s_vld;
  logic [W-1:0] s_pld;
  logic         s_rdy;
  logic         link_vld;
  logic [W-1:0] link_flit;
  logic         link_crd_rtn;
  logic         crd_err;

  always #5 clk = ~clk;

  dti_pr_iniu_noc_tx #(
    .PLD_WIDTH    (W),
    .CREDIT_NUM   (N),
    .CREDIT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .partial_reset (partial_reset),
    .idle          (idle),
    .s_vld         (s_vld),
    .s_pld         (s_pld),
    .s_rdy         (s_rdy),
    .link_vld      (link_vld),
    .link_flit     (link_flit),
    .link_crd_rtn  (link_crd_rtn),
    .crd_err       (crd_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of buffered flits, credit count, open-packet flag,
  // quiesce mode (0 run, 1 draining, 2 quiet), registered link output.
  logic [W-1:0] m_buf[$];
  int           m_crd;
  bit           m_pkt;
  int           m_st;
  bit           m_lvld;
  logic [W-1:0] m_lflit;
  bit           m_err;
  int           pulses;
  logic [W-1:0] src_q[$];

  task automatic m_reset();
    m_buf.delete();
    m_crd   = N;
    m_pkt   = 1'b0;
    m_st    = 0;
    m_lvld  = 1'b0;
    m_lflit = '0;
    m_err   = 1'b0;
  endtask

  function automatic logic [W-1:0] mk(input bit last);
    logic [127:0] r;
    logic [W-1:0] f;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    f = r[W-1:0];
    f[0] = last;
    return f;
  endfunction

  task automatic cyc(input bit v, input logic [W-1:0] p, input bit rt, input bit pr, output bit acc);
    bit srdy, send;
    int nst;
    s_vld = v; s_pld = p; link_crd_rtn = rt; partial_reset = pr;
    @(negedge clk);
    srdy = (m_buf.size() < 2) && ((m_st == 0) || (m_st == 1 && m_pkt));
    check_val("s_rdy", W'(s_rdy), W'(srdy));
    check_val("idle", W'(idle), W'(m_buf.size() == 0 && !m_pkt && m_crd == N && !m_lvld));
    check_val("link_vld", W'(link_vld), W'(m_lvld));
    check_val("link_flit", link_flit, m_lflit);
    check_val("crd_err", W'(crd_err), W'(m_err));
    if (link_vld) pulses++;
    acc  = v && srdy;
    send = (m_buf.size() > 0) && (m_crd > 0);
    nst  = m_st;
    if (m_st == 0 && pr) nst = 1;
    else if (m_st == 1 && !pr) nst = 0;
    else if (m_st == 1 && !m_pkt && m_buf.size() == 0 && m_crd == N) nst = 2;
    else if (m_st == 2 && !pr) nst = 0;
    @(posedge clk);
    #1;
    m_lvld = send;
    if (send) m_lflit = m_buf.pop_front();
    if (acc) begin
      m_buf.push_back(p);
      m_pkt = !p[0];
    end
    m_crd = m_crd - int'(send) + int'(rt);
    if (m_crd > N) begin
      m_crd = N;
      m_err = 1'b1;
    end
    m_st = nst;
  endtask

  // rmode: 0 no returns, 1 random returns, 2 return whenever credit is out.
  task automatic drive(input int ncyc, input bit pr, input int rmode);
    for (int i = 0; i < ncyc; i++) begin
      bit v, rt, acc;
      logic [W-1:0] p;
      v = src_q.size() > 0;
      p = v ? src_q[0] : '0;
      case (rmode)
        0:       rt = 1'b0;
        1:       rt = (m_crd < N) && ($urandom_range(2) == 0);
        default: rt = (m_crd < N);
      endcase
      cyc(v, p, rt, pr, acc);
      if (acc) void'(src_q.pop_front());
    end
  endtask

  initial begin
    bit acc;
    bit pr_rnd;
    rst = 1'b1; partial_reset = 1'b0; s_vld = 1'b0; s_pld = '0; link_crd_rtn = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Credit exhaustion: 6 single-flit packets, no returns.
    pulses = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1'b1));
    drive(12, 1'b0, 0);
    check_val("exh_pulses", W'(pulses), W'(4));
    check_val("exh_accepted", W'(src_q.size()), W'(0));
    check_val("exh_srdy", W'(s_rdy), W'(0));
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    check_val("exh_fifth", W'(pulses), W'(5));
    drive(30, 1'b0, 2);
    check_val("exh_idle", W'(idle), W'(1));

    // Send and return in the same cycle at credit 2.
    src_q.push_back(mk(1'b1));
    src_q.push_back(mk(1'b1));
    drive(5, 1'b0, 0);
    cyc(1'b1, mk(1'b1), 1'b0, 1'b0, acc);
    pulses = 0;
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check_val("sim_lvld", W'(link_vld), W'(1));
    for (int i = 0; i < 3; i++) src_q.push_back(mk(1'b1));
    drive(10, 1'b0, 0);
    check_val("sim_pulses", W'(pulses), W'(3));
    drive(30, 1'b0, 2);
    check_val("sim_idle", W'(idle), W'(1));

    // Packet-atomic drain: partial_reset after flit 1 of a 3-flit packet.
    src_q.push_back(mk(1'b0));
    drive(2, 1'b0, 1);
    src_q.push_back(mk(1'b0));
    src_q.push_back(mk(1'b1));
    src_q.push_back(mk(1'b0));
    drive(3, 1'b1, 0);
    check_val("drn_left", W'(src_q.size()), W'(1));
    check_val("drn_srdy", W'(s_rdy), W'(0));
    drive(30, 1'b1, 2);
    check_val("drn_idle", W'(idle), W'(1));
    check_val("drn_quiet_srdy", W'(s_rdy), W'(0));
    drive(2, 1'b0, 0);
    src_q.push_back(mk(1'b1));
    drive(30, 1'b0, 2);
    check_val("drn_done", W'(idle), W'(1));

    // Drain abort: two cycles of partial_reset while credit is out.
    src_q.push_back(mk(1'b1));
    drive(3, 1'b0, 0);
    drive(2, 1'b1, 0);
    check_val("abort_drain_srdy", W'(s_rdy), W'(0));
    drive(1, 1'b0, 0);
    check_val("abort_srdy", W'(s_rdy), W'(1));
    src_q.push_back(mk(1'b0));
    src_q.push_back(mk(1'b1));
    drive(30, 1'b0, 2);
    check_val("abort_idle", W'(idle), W'(1));

    // Randomized traffic with occasional quiesce requests.
    pr_rnd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (src_q.size() < 3 && $urandom_range(3) != 0) src_q.push_back(mk(1'($urandom_range(1))));
      if ($urandom_range(24) == 0) pr_rnd = ~pr_rnd;
      drive(1, pr_rnd, 1);
    end
    src_q.push_back(mk(1'b1));
    drive(60, 1'b0, 2);
    check_val("rnd_idle", W'(idle), W'(1));
    check_val("rnd_err", W'(crd_err), W'(0));

    // Credit overflow at full credit.
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check_val("ovf_err", W'(crd_err), W'(1));
    drive(4, 1'b0, 0);
    check_val("ovf_sticky", W'(crd_err), W'(1));
    pulses = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1'b1));
    drive(12, 1'b0, 0);
    check_val("ovf_credit", W'(pulses), W'(4));
    drive(30, 1'b0, 2);

    // Async reset with 2 flits buffered and a packet open.
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1'b0));
    drive(12, 1'b0, 0);
    check_val("rst_pre_idle", W'(idle), W'(0));
    #2 rst = 1'b1;
    #1;
    check_val("rst_lvld", W'(link_vld), W'(0));
    check_val("rst_err", W'(crd_err), W'(0));
    check_val("rst_idle", W'(idle), W'(1));
    check_val("rst_srdy", W'(s_rdy), W'(1));
    m_reset();
    src_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    pulses = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1'b1));
    drive(12, 1'b0, 0);
    check_val("rst_credit", W'(pulses), W'(4));
    drive(30, 1'b0, 2);
    check_val("final_idle", W'(idle), W'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
